display_multiplex_hex8: RTL and testbench

- Drives an 8-digit multiplexed 7-segment display (common-cathode) from a 32-bit value shown as 8 hex digits, plus per-digit decimal points.
- An internal strobe generator produces a one-clock pulse every SWITCH_PERIOD_US microseconds. Each pulse advances a digit selector.
- Leading-zero blanking hides high-order zero digits.
- Sits between the system register/bus logic and the display pins.

---
 rtl/display_multiplex_hex8.sv | 94 +++++++++
 tb/tb_display_multiplex_hex8.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/display_multiplex_hex8.sv
// 8-digit multiplexed common-cathode 7-segment driver with hex decode and leading-zero blanking.
// Optional anti-ghosting blank cycle on each digit switch: define DISPLAY_GHOST_GAP_EN.
module display_multiplex_hex8 #(
  parameter int CLOCK_HZ         = 10_000_000,
  parameter int SWITCH_PERIOD_US = 1000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Data_i,
  input  logic [7:0]  DecimalPoints_i,
  output logic [7:0]  Cathodes_o,
  output logic [7:0]  Segments_o
);

  // DELAY must be at least 2 so the strobe is a single-clock pulse
  localparam int DELAY = CLOCK_HZ / 1_000_000 * SWITCH_PERIOD_US;
  localparam int CW    = (DELAY > 2) ? $clog2(DELAY) : 1;
  localparam logic [CW-1:0] LAST = CW'(DELAY - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [7:0]    cath_q, cath_d;
  logic [7:0]    seg_q, seg_d;
  logic          switch_s;
  logic          gap_s;
  logic          enable_s;
  logic [3:0]    nibble_s;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0:    p = 7'h3F;
      4'h1:    p = 7'h06;
      4'h2:    p = 7'h5B;
      4'h3:    p = 7'h4F;
      4'h4:    p = 7'h66;
      4'h5:    p = 7'h6D;
      4'h6:    p = 7'h7D;
      4'h7:    p = 7'h07;
      4'h8:    p = 7'h7F;
      4'h9:    p = 7'h6F;
      4'hA:    p = 7'h77;
      4'hB:    p = 7'h7C;
      4'hC:    p = 7'h39;
      4'hD:    p = 7'h5E;
      4'hE:    p = 7'h79;
      4'hF:    p = 7'h71;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // Strobe counter, digit selector and the next registered output values
  always_comb begin
    switch_s = (cnt_q == LAST);
    cnt_d    = switch_s ? '0 : cnt_q + CW'(1);
    sel_d    = switch_s ? sel_q + 3'd1 : sel_q;
    nibble_s = Data_i[{sel_q, 2'b00} +: 4];

    // Digit is lit when it is digit 0 or any nibble at or above it is nonzero
    enable_s = (sel_q == 3'd0);
    for (int k = 0; k < 8; k++) begin
      enable_s = enable_s | ((3'(k) >= sel_q) && (Data_i[4*k +: 4] != 4'h0));
    end

`ifdef DISPLAY_GHOST_GAP_EN
    gap_s = switch_s;
`else
    gap_s = 1'b0;
`endif

    cath_d = gap_s ? 8'hFF : ~(8'b1 << sel_q);
    seg_d  = gap_s ? 8'h00 : {DecimalPoints_i[sel_q], (enable_s ? hex7(nibble_s) : 7'h00)};
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q  <= '0;
      sel_q  <= 3'd0;
      cath_q <= 8'hFF;
      seg_q  <= 8'h00;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      cath_q <= cath_d;
      seg_q  <= seg_d;
    end
  end

  assign Cathodes_o = cath_q;
  assign Segments_o = seg_q;

endmodule

// File: tb/tb_display_multiplex_hex8.sv
// Randomized self-checking bench for display_multiplex_hex8 against an arithmetic reference model.
module tb_display_multiplex_hex8;

  localparam int DELAY = 10;
  localparam bit [6:0] HEX_TAB [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam bit [7:0] SEG_BEEF [0:7] = '{8'hF1, 8'h79, 8'h79, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam bit [7:0] SEG_8000 [0:7] = '{8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'hFF};

  logic        Clock;
  logic        Reset;
  logic [31:0] Data_i;
  logic [7:0]  DecimalPoints_i;
  logic [7:0]  Cathodes_o;
  logic [7:0]  Segments_o;

  int          checks;
  int          errors;
  int          edges;
  int          n_m;
  logic [15:0] exp_q;

  display_multiplex_hex8 #(.CLOCK_HZ(10_000_000), .SWITCH_PERIOD_US(1)) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Data_i          (Data_i),
    .DecimalPoints_i (DecimalPoints_i),
    .Cathodes_o      (Cathodes_o),
    .Segments_o      (Segments_o)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Outputs registered at the clock edge that ends cycle n (n = edges since reset release)
  function automatic logic [15:0] model_out(input int n, input logic [31:0] d, input logic [7:0] dp);
    int sel;
    int nib;
    bit en;
    sel = (n / DELAY) % 8;
`ifdef DISPLAY_GHOST_GAP_EN
    if (n % DELAY == DELAY - 1) return 16'hFF00;
`endif
    nib = int'((d >> (4 * sel)) & 32'hF);
    en  = (sel == 0) || ((d >> (4 * sel)) != 32'h0);
    return {~(8'd1 << sel), dp[sel], (en ? HEX_TAB[nib] : 7'h00)};
  endfunction

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      n_m   <= 0;
      exp_q <= 16'hFF00;
    end else begin
      exp_q <= model_out(n_m, Data_i, DecimalPoints_i);
      n_m   <= n_m + 1;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edges);
    end
  endtask

  task automatic at_neg();
    @(negedge Clock);
    edges++;
    chk("model", {Cathodes_o, Segments_o}, exp_q);
  endtask

  task automatic advance_to(input int target);
    while (edges < target) at_neg();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edges  = 0;
    Reset  = 1'b0;
    Data_i = 32'h0000BEEF;
    DecimalPoints_i = 8'h01;

    repeat (3) at_neg();
    chk("reset_hold", {Cathodes_o, Segments_o}, 16'hFF00);

    Reset = 1'b1;
    edges = 0;
    at_neg();
    chk("first_digit", {Cathodes_o, Segments_o}, 16'hFEF1);

    for (int k = 1; k < 8; k++) begin
      advance_to(k * DELAY + 5);
      chk("beef_digit", {Cathodes_o, Segments_o}, {~(8'd1 << k), SEG_BEEF[k]});
    end
    advance_to(8 * DELAY + 1);
    chk("selector_wrap", {Cathodes_o, Segments_o}, 16'hFEF1);

    Data_i = 32'h0;
    DecimalPoints_i = 8'h00;
    for (int k = 0; k < 8; k++) begin
      advance_to(8 * DELAY + 5 + k * DELAY);
      chk("zero_data", {Cathodes_o, Segments_o}, {~(8'd1 << k), (k == 0) ? 8'h3F : 8'h00});
    end

    Data_i = 32'h80000000;
    DecimalPoints_i = 8'h80;
    for (int k = 0; k < 8; k++) begin
      advance_to(16 * DELAY + 5 + k * DELAY);
      chk("msd_only", {Cathodes_o, Segments_o}, {~(8'd1 << k), SEG_8000[k]});
    end

    advance_to(29 * DELAY + 5);
    chk("pre_reset_sel5", {Cathodes_o, Segments_o}, 16'hDF3F);
    #2 Reset = 1'b0;
    #1 chk("async_reset", {Cathodes_o, Segments_o}, 16'hFF00);
    repeat (2) at_neg();
    Reset = 1'b1;
    edges = 0;
    at_neg();
    chk("restart_digit0", {Cathodes_o, Segments_o}, 16'hFE3F);
    advance_to(DELAY);
`ifdef DISPLAY_GHOST_GAP_EN
    chk("strobe_edge", {Cathodes_o, Segments_o}, 16'hFF00);
`else
    chk("strobe_edge", {Cathodes_o, Segments_o}, 16'hFE3F);
`endif
    advance_to(DELAY + 1);
    chk("restart_digit1", {Cathodes_o, Segments_o}, 16'hFD3F);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) Data_i = $urandom >> (4 * $urandom_range(0, 8));
      if ($urandom_range(0, 3) == 0) DecimalPoints_i = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 Reset = 1'b0;
        #1 chk("rand_async_reset", {Cathodes_o, Segments_o}, 16'hFF00);
        repeat ($urandom_range(1, 3)) at_neg();
        Reset = 1'b1;
        edges = 0;
      end
      at_neg();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
